// File: rtl/tnn_frame_pkg.sv
// Shared types and helpers for the TNN feature framer: FSM state encoding
// and the shift-and-saturate quantizer.
package tnn_frame_pkg;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    FULL    = 2'd1,
    DISCARD = 2'd2
  } frame_state_t;

  localparam int unsigned FEAT_W_DEF = 3;
  localparam int unsigned FEAT_MAX   = (1 << FEAT_W_DEF) - 1;

  // Widths are passed in so one helper serves every parameterisation.
  function automatic logic [31:0] sat_quant(input logic [31:0] raw,
                                            input int unsigned shift,
                                            input int unsigned feat_w);
    logic [31:0] q;
    logic [31:0] lim;
    q   = raw >> shift;
    lim = (32'd1 << feat_w) - 32'd1;
    return (q > lim) ? lim : q;
  endfunction

endpackage

// File: rtl/tnn_sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones, never wraps.
module tnn_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/tnn_feature_framer.sv
// Serial raw-sample to quantized-feature frame assembler with a fill register
// and an output register, presented on a valid/ready interface.
module tnn_feature_framer
  import tnn_frame_pkg::*;
#(
  parameter int unsigned RAW_W  = 8,
  parameter int unsigned FEAT_W = 3,
  parameter int unsigned N_FEAT = 6,
  parameter int unsigned SHIFT  = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [RAW_W-1:0]         s_data,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [N_FEAT*FEAT_W-1:0] m_feat,
  output logic [CNT_W-1:0]         frame_cnt,
  output logic [CNT_W-1:0]         err_cnt,
  output logic                     err_pulse
);

  localparam int unsigned IDX_W   = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int unsigned FRAME_W = N_FEAT * FEAT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

  frame_state_t       state, state_next;
  logic [IDX_W-1:0]   idx, idx_next;
  logic [FRAME_W-1:0] fill_reg, fill_next;
  logic               fill_full;
  logic               accept;
  logic               transfer;
  logic               deliver;
  logic               err_evt;
  logic [FEAT_W-1:0]  q;

  assign fill_full = (state == FULL);
  assign s_ready   = !fill_full;
  assign accept    = s_valid & s_ready;
  assign transfer  = fill_full & (!m_valid | m_ready);
  assign deliver   = m_valid & m_ready;
  assign q         = FEAT_W'(sat_quant(32'(s_data), SHIFT, FEAT_W));

  always_comb begin
    state_next = state;
    idx_next   = idx;
    fill_next  = fill_reg;
    err_evt    = 1'b0;
    case (state)
      FILL: begin
        if (accept) begin
          fill_next[idx*FEAT_W +: FEAT_W] = q;
          if (s_last) begin
            idx_next = '0;
            if (idx == LAST_IDX) begin
              state_next = FULL;
            end else begin
              err_evt = 1'b1;
            end
          end else if (idx == LAST_IDX) begin
            // Overlong frame: last field is written, remainder is swallowed.
            idx_next   = '0;
            state_next = DISCARD;
          end else begin
            idx_next = idx + IDX_W'(1);
          end
        end
      end
      DISCARD: begin
        if (accept && s_last) begin
          err_evt    = 1'b1;
          state_next = FILL;
        end
      end
      FULL: begin
        if (transfer) begin
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      idx      <= '0;
      fill_reg <= '0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      fill_reg <= fill_next;
    end
  end

  // Output register: a transfer takes priority so handshake+reload has no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid   <= 1'b0;
      m_feat    <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= err_evt;
      if (transfer) begin
        m_valid <= 1'b1;
        m_feat  <= fill_reg;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  tnn_sat_counter #(.WIDTH(CNT_W)) u_frame_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (deliver),
    .count (frame_cnt)
  );

  tnn_sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_evt),
    .count (err_cnt)
  );

endmodule

// File: tb/tb_tnn_feature_framer.sv
// Self-checking bench for tnn_feature_framer: directed scenarios plus a
// randomized packet stream checked against a packet-level reference model.
module tb_tnn_feature_framer;

  localparam int FW = 3;
  localparam int NF = 6;
  localparam int BW = NF * FW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = '0;
  logic          s_last = 1'b0;
  logic          m_ready = 1'b0;
  logic          s_ready, m_valid, err_pulse;
  logic [BW-1:0] m_feat;
  logic [15:0]   frame_cnt, err_cnt;
  logic          s_ready2, m_valid2, err_pulse2;
  logic [BW-1:0] m_feat2;
  logic [15:0]   frame_cnt2, err_cnt2;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] pkt [16];

  always #5 clk = ~clk;

  tnn_feature_framer #(.RAW_W(8), .FEAT_W(FW), .N_FEAT(NF), .SHIFT(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_feat(m_feat),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt), .err_pulse(err_pulse));

  tnn_feature_framer #(.RAW_W(8), .FEAT_W(FW), .N_FEAT(NF), .SHIFT(3), .CNT_W(16)) dut_s3 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid2), .m_ready(m_ready), .m_feat(m_feat2),
    .frame_cnt(frame_cnt2), .err_cnt(err_cnt2), .err_pulse(err_pulse2));

  function automatic int quant(input int raw, input int sh);
    int q;
    q = raw >> sh;
    return (q > 7) ? 7 : q;
  endfunction

  // Expected frame from the first NF entries of pkt.
  function automatic logic [BW-1:0] exp_frame(input int sh);
    logic [BW-1:0] f;
    f = '0;
    for (int k = 0; k < NF; k++) f[k*FW +: FW] = FW'(quant(int'(pkt[k]), sh));
    return f;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat was accepted.
  task automatic send_beat(input logic [7:0] d, input logic l);
    bit ok;
    ok = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: s_ready=%0b required 1 within 200 cycles", s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_pkt(input int len);
    for (int i = 0; i < len; i++) send_beat(pkt[i], (i == len - 1));
  endtask

  task automatic rand_pkt(input int len);
    for (int i = 0; i < len; i++) pkt[i] = 8'($urandom);
  endtask

  task automatic wait_valid();
    for (int t = 0; t < 20 && !m_valid; t++) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %b required 0", m_valid); end
    n_checks++; if (m_feat !== '0) begin n_fail++; $display("FAIL rst_m_feat: got %h required 0", m_feat); end
    n_checks++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_frame_cnt: got %0d required 0", frame_cnt); end
    n_checks++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_err_cnt: got %0d required 0", err_cnt); end
    n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_err_pulse: got %b required 0", err_pulse); end
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_s_ready: got %b required 1", s_ready); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    logic [BW-1:0] e;
    do_reset();
    m_ready = 1'b1;
    pkt[0] = 8'h00; pkt[1] = 8'h20; pkt[2] = 8'h40; pkt[3] = 8'h60; pkt[4] = 8'h80; pkt[5] = 8'hFF;
    e = '0;
    e[0+:3] = 3'd0; e[3+:3] = 3'd1; e[6+:3] = 3'd2; e[9+:3] = 3'd3; e[12+:3] = 3'd4; e[15+:3] = 3'd7;
    send_pkt(6);
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL nom_pre_valid: got %b required 0", m_valid); end
    @(posedge clk); #1;
    n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL nom_valid: got %b required 1", m_valid); end
    n_checks++; if (m_feat !== e) begin n_fail++; $display("FAIL nom_feat: got %h required %h", m_feat, e); end
    @(posedge clk); #1;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL nom_drop: got %b required 0", m_valid); end
    n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL nom_frame_cnt: got %0d required 1", frame_cnt); end
  endtask

  task automatic test_saturation();
    logic [BW-1:0] e3, e5;
    do_reset();
    m_ready = 1'b1;
    pkt[0] = 8'hFF; pkt[1] = 8'h38; pkt[2] = 8'h37; pkt[3] = 8'h00; pkt[4] = 8'h1F; pkt[5] = 8'h20;
    e3 = exp_frame(3);
    e5 = exp_frame(5);
    send_pkt(6);
    wait_valid();
    n_checks++; if (m_valid2 !== 1'b1) begin n_fail++; $display("FAIL sat_valid: got %b required 1", m_valid2); end
    n_checks++; if (m_feat2 !== e3) begin n_fail++; $display("FAIL sat_feat_shift3: got %h required %h", m_feat2, e3); end
    n_checks++; if (m_feat2[8:0] !== 9'o677) begin n_fail++; $display("FAIL sat_edge_fields: got %o required 677", m_feat2[8:0]); end
    n_checks++; if (m_feat !== e5) begin n_fail++; $display("FAIL sat_feat_shift5: got %h required %h", m_feat, e5); end
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] ea, eb;
    do_reset();
    m_ready = 1'b0;
    rand_pkt(6); ea = exp_frame(5); send_pkt(6);
    rand_pkt(6); eb = exp_frame(5); send_pkt(6);
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_s_ready: got %b required 0", s_ready); end
    n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b required 1", m_valid); end
    repeat (3) @(posedge clk); #1;
    n_checks++; if (m_feat !== ea) begin n_fail++; $display("FAIL bp_hold_a: got %h required %h", m_feat, ea); end
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_s_ready_hold: got %b required 0", s_ready); end
    m_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_no_bubble: got %b required 1", m_valid); end
    n_checks++; if (m_feat !== eb) begin n_fail++; $display("FAIL bp_frame_b: got %h required %h", m_feat, eb); end
    @(posedge clk); #1;
    m_ready = 1'b0;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b required 0", m_valid); end
    n_checks++; if (frame_cnt !== 16'd2) begin n_fail++; $display("FAIL bp_frame_cnt: got %0d required 2", frame_cnt); end
  endtask

  task automatic test_early_last();
    logic [BW-1:0] e;
    do_reset();
    m_ready = 1'b1;
    rand_pkt(3); send_pkt(3);
    n_checks++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL early_pulse: got %b required 1", err_pulse); end
    n_checks++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL early_err_cnt: got %0d required 1", err_cnt); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL early_no_valid: got %b required 0", m_valid); end
    @(posedge clk); #1;
    n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL early_pulse_width: got %b required 0", err_pulse); end
    rand_pkt(6); e = exp_frame(5); send_pkt(6);
    wait_valid();
    n_checks++; if (m_feat !== e || m_valid !== 1'b1) begin n_fail++; $display("FAIL early_next_frame: got %h v=%b required %h v=1", m_feat, m_valid, e); end
    n_checks++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL early_err_cnt_hold: got %0d required 1", err_cnt); end
  endtask

  task automatic test_late_last();
    logic [BW-1:0] e;
    do_reset();
    m_ready = 1'b1;
    rand_pkt(9); send_pkt(9);
    n_checks++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL late_pulse: got %b required 1", err_pulse); end
    n_checks++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL late_err_cnt: got %0d required 1", err_cnt); end
    @(posedge clk); #1;
    n_checks++; if (m_valid !== 1'b0 || frame_cnt !== 16'd0) begin n_fail++; $display("FAIL late_no_frame: got v=%b cnt=%0d required v=0 cnt=0", m_valid, frame_cnt); end
    rand_pkt(6); e = exp_frame(5); send_pkt(6);
    wait_valid();
    n_checks++; if (m_feat !== e || m_valid !== 1'b1) begin n_fail++; $display("FAIL late_next_frame: got %h v=%b required %h v=1", m_feat, m_valid, e); end
  endtask

  task automatic test_reset_midframe();
    logic [BW-1:0] e;
    do_reset();
    m_ready = 1'b1;
    rand_pkt(6); send_pkt(6);
    wait_valid();
    @(posedge clk); #1;
    m_ready = 1'b0;
    rand_pkt(6); send_pkt(6);
    rand_pkt(4); send_pkt(4);
    rst_n = 1'b0;
    #2;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b required 0", m_valid); end
    n_checks++; if (frame_cnt !== 16'd0 || err_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_rst_cnt: got %0d/%0d required 0/0", frame_cnt, err_cnt); end
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_s_ready: got %b required 1", s_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_ready = 1'b1;
    rand_pkt(6); e = exp_frame(5); send_pkt(6);
    wait_valid();
    n_checks++; if (m_feat !== e || m_valid !== 1'b1) begin n_fail++; $display("FAIL mid_fresh_frame: got %h v=%b required %h v=1", m_feat, m_valid, e); end
    @(posedge clk); #1;
    n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL mid_fresh_cnt: got %0d required 1", frame_cnt); end
  endtask

  task automatic test_random();
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] got, want, held;
    int exp_err, exp_frames, pulses, len, cycles;
    bit drv_done, chk_done, hold;
    exp_err = 0; exp_frames = 0; pulses = 0; cycles = 0;
    drv_done = 0; chk_done = 0; hold = 0; held = '0;
    do_reset();
    fork
      begin
        for (int p = 0; p < 40; p++) begin
          len = NF;
          if ($urandom_range(0, 3) == 0) begin
            len = $urandom_range(1, 9);
            if (len >= NF) len++;
          end
          rand_pkt(len);
          if (len == NF) begin exp_q.push_back(exp_frame(5)); exp_frames++; end
          else exp_err++;
          for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_beat(pkt[i], (i == len - 1));
          end
        end
        drv_done = 1;
      end
      begin
        while (!chk_done) begin
          @(posedge clk); #1;
          m_ready = ($urandom_range(0, 3) != 0);
        end
        m_ready = 1'b1;
      end
      begin
        while (!(drv_done && exp_q.size() == 0)) begin
          @(negedge clk);
          cycles++;
          if (cycles > 30000) begin
            n_checks++; n_fail++;
            $display("FAIL rnd_timeout: %0d frames outstanding required 0", exp_q.size());
            break;
          end
          if (err_pulse) pulses++;
          if (hold) begin
            n_checks++;
            if (m_valid !== 1'b1 || m_feat !== held) begin n_fail++; $display("FAIL rnd_stable: got %h v=%b required %h v=1", m_feat, m_valid, held); end
          end
          if (m_valid && m_ready) begin
            got = m_feat;
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL rnd_extra_frame: got %h required none", got); end
            else begin
              want = exp_q.pop_front();
              if (got !== want) begin n_fail++; $display("FAIL rnd_frame: got %h required %h", got, want); end
            end
          end
          hold = m_valid && !m_ready;
          held = m_feat;
        end
        repeat (6) begin @(negedge clk); if (err_pulse) pulses++; end
        chk_done = 1;
      end
    join
    @(posedge clk); #1;
    n_checks++; if (frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL rnd_frame_cnt: got %0d required %0d", frame_cnt, exp_frames); end
    n_checks++; if (err_cnt !== 16'(exp_err)) begin n_fail++; $display("FAIL rnd_err_cnt: got %0d required %0d", err_cnt, exp_err); end
    n_checks++; if (pulses != exp_err) begin n_fail++; $display("FAIL rnd_err_pulses: got %0d required %0d", pulses, exp_err); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_saturation();
    test_backpressure();
    test_early_last();
    test_late_last();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
